bram_port_ctrl: RTL

BRAM_PORT_CTRL -- requirements
Module: bram_port_ctrl

---
 rtl/bram_port_ctrl_if.sv | 32 +++
 rtl/bram_port_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/bram_port_ctrl_if.sv
// Request/response handshake bundle for bram_port_ctrl.
//   slave  : the controller (accepts requests, produces responses)
//   master : the requester (offers requests, consumes responses)
// Signals:
//   I_REQ_VALID/O_REQ_READY : request handshake
//   I_REQ_WE/ADDR/DATA      : request payload (1 = write)
//   O_RSP_VALID/I_RSP_READY : response handshake
//   O_RSP_DATA/O_RSP_WE     : response payload (read data or echoed write data)
interface bram_port_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  I_REQ_VALID;
  logic                  O_REQ_READY;
  logic                  I_REQ_WE;
  logic [ADDR_WIDTH-1:0] I_REQ_ADDR;
  logic [DATA_WIDTH-1:0] I_REQ_DATA;
  logic                  O_RSP_VALID;
  logic                  I_RSP_READY;
  logic [DATA_WIDTH-1:0] O_RSP_DATA;
  logic                  O_RSP_WE;

  modport slave (
    input  I_REQ_VALID, I_REQ_WE, I_REQ_ADDR, I_REQ_DATA, I_RSP_READY,
    output O_REQ_READY, O_RSP_VALID, O_RSP_DATA, O_RSP_WE
  );

  modport master (
    output I_REQ_VALID, I_REQ_WE, I_REQ_ADDR, I_REQ_DATA, I_RSP_READY,
    input  O_REQ_READY, O_RSP_VALID, O_RSP_DATA, O_RSP_WE
  );
endinterface

// File: rtl/bram_port_ctrl.sv
// Single-port BRAM access controller: one transaction in flight at a time,
// IDLE -> ISSUE -> CAPTURE -> RESPOND, response three cycles after the
// request handshake.
// Ports:
//   I_CLK, I_NRESET : clock, synchronous active-low reset
//   bus             : request/response handshake (slave modport)
//   O_BRAM_ADDR/DATA/WE : BRAM port drive, valid during ISSUE
//   I_BRAM_Q        : BRAM registered read data (one clock after address)
//   O_RD_COUNT/O_WR_COUNT : completed read/write responses, wrapping
module bram_port_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  bram_port_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] O_BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] O_BRAM_DATA,
  output logic                  O_BRAM_WE,
  input  logic [DATA_WIDTH-1:0] I_BRAM_Q,
  output logic [15:0]           O_RD_COUNT,
  output logic [15:0]           O_WR_COUNT
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t      state;
  logic        req_we;   // WE of the request in flight (BRAM strobe drops after ISSUE)
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  assign O_RD_COUNT = rd_cnt;
  assign O_WR_COUNT = wr_cnt;

  // O_BRAM_ADDR/O_BRAM_DATA double as the registered request address/data:
  // they load on the handshake and hold until the next one.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state           <= IDLE;
      req_we          <= 1'b0;
      bus.O_REQ_READY <= 1'b0;
      bus.O_RSP_VALID <= 1'b0;
      bus.O_RSP_DATA  <= '0;
      bus.O_RSP_WE    <= 1'b0;
      O_BRAM_ADDR     <= '0;
      O_BRAM_DATA     <= '0;
      O_BRAM_WE       <= 1'b0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Ready is registered, so the first cycle out of reset still
          // shows 0 to the requester and must not count as a handshake.
          if (bus.I_REQ_VALID && bus.O_REQ_READY) begin
            req_we          <= bus.I_REQ_WE;
            O_BRAM_ADDR     <= bus.I_REQ_ADDR;
            O_BRAM_DATA     <= bus.I_REQ_DATA;
            O_BRAM_WE       <= bus.I_REQ_WE;
            bus.O_REQ_READY <= 1'b0;
            state           <= ISSUE;
          end else begin
            bus.O_REQ_READY <= 1'b1;
          end
        end
        ISSUE: begin
          O_BRAM_WE <= 1'b0;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          // Writes echo their own data so the response does not depend on
          // the BRAM read-during-write behaviour.
          bus.O_RSP_DATA  <= req_we ? O_BRAM_DATA : I_BRAM_Q;
          bus.O_RSP_WE    <= req_we;
          bus.O_RSP_VALID <= 1'b1;
          state           <= RESPOND;
        end
        RESPOND: begin
          if (bus.I_RSP_READY) begin
            bus.O_RSP_VALID <= 1'b0;
            bus.O_REQ_READY <= 1'b1;
            state           <= IDLE;
            if (bus.O_RSP_WE) wr_cnt <= wr_cnt + 16'd1;
            else              rd_cnt <= rd_cnt + 16'd1;
          end
        end
        default: begin
          state           <= IDLE;
          bus.O_REQ_READY <= 1'b0;
          bus.O_RSP_VALID <= 1'b0;
          O_BRAM_WE       <= 1'b0;
        end
      endcase
    end
  end
endmodule
